// File: rtl/cpu_pkg.sv
// Shared CPU-side bus definitions: bus interface FSM states, bus direction encoding
// and the access-timeout limit used when BUS_IF_TIMEOUT_EN is defined.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACCESS = 2'd2,
      WAIT   = 2'd3
   } bus_if_state_e;

   localparam logic       BUS_READ           = 1'b1;
   localparam logic       BUS_WRITE          = 1'b0;
   localparam logic [7:0] BUS_TIMEOUT_CYCLES = 8'd255;

endpackage

// File: rtl/bus_if.sv
// Memory-access bus master: latches one request, arbitrates, runs one bus access.
// Latency: read data appears combinationally on the rdy cycle (min 2 cycles after as_i).
// Backpressure: busy_o stalls upstream until completion; stall_i parks completed data in WAIT.
// Optional macro BUS_IF_TIMEOUT_EN adds an access timeout reported on bus_err_o.
module bus_if
   import cpu_pkg::*;
#(
   parameter int WORD_DATA_WIDTH = 32,
   parameter int WORD_ADDR_WIDTH = 30
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall_i,
   input  logic                       flush_i,
   output logic                       busy_o,
   input  logic [WORD_ADDR_WIDTH-1:0] addr_i,
   input  logic                       as_i,
   input  logic                       rw_i,
   input  logic [WORD_DATA_WIDTH-1:0] wr_data_i,
   output logic [WORD_DATA_WIDTH-1:0] rd_data_o,
   output logic                       bus_req_o,
   input  logic                       bus_grant_i,
   output logic [WORD_ADDR_WIDTH-1:0] bus_addr_o,
   output logic                       bus_as_o,
   output logic                       bus_rw_o,
   output logic [WORD_DATA_WIDTH-1:0] bus_wr_data_o,
   input  logic [WORD_DATA_WIDTH-1:0] bus_rd_data_i,
   input  logic                       bus_rdy_i,
   output logic                       bus_err_o
);

   bus_if_state_e              state, next_state;
   logic [WORD_ADDR_WIDTH-1:0] req_addr;
   logic                       req_rw;
   logic [WORD_DATA_WIDTH-1:0] req_wdata;
   logic [WORD_DATA_WIDTH-1:0] rd_buf;
   logic                       flush_seen;
   logic                       flushed;
   logic                       accept;
   logic                       timeout_hit;

   // A flush in the completing cycle counts as well as one seen earlier in ACCESS.
   assign flushed = flush_seen | flush_i;
   assign accept  = (state == IDLE) && as_i && !flush_i;

`ifdef BUS_IF_TIMEOUT_EN
   logic [7:0] to_cnt;

   // Fires on the last tolerated non-ready ACCESS cycle; the access is abandoned.
   assign timeout_hit = (state == ACCESS) && !bus_rdy_i
                        && (to_cnt == BUS_TIMEOUT_CYCLES - 8'd1);
   assign bus_err_o   = timeout_hit && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= 8'd0;
      end else if (state == REQ && next_state == ACCESS) begin
         to_cnt <= 8'd0;
      end else if (state == ACCESS && !bus_rdy_i) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_err_o   = 1'b0;
`endif

   always_comb begin
      next_state    = state;
      busy_o        = 1'b0;
      bus_req_o     = 1'b0;
      bus_as_o      = 1'b0;
      bus_addr_o    = '0;
      bus_rw_o      = 1'b0;
      bus_wr_data_o = '0;
      rd_data_o     = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  busy_o     = 1'b1;
                  bus_req_o  = 1'b1;
                  next_state = REQ;
               end
            end
            REQ: begin
               busy_o = 1'b1;
               if (flush_i) begin
                  next_state = IDLE;
               end else begin
                  bus_req_o = 1'b1;
                  if (bus_grant_i) next_state = ACCESS;
               end
            end
            ACCESS: begin
               busy_o        = 1'b1;
               bus_req_o     = 1'b1;
               bus_as_o      = 1'b1;
               bus_addr_o    = req_addr;
               bus_rw_o      = req_rw;
               bus_wr_data_o = req_wdata;
               if (bus_rdy_i) begin
                  busy_o = 1'b0;
                  if (req_rw == BUS_READ && !flushed) rd_data_o = bus_rd_data_i;
                  next_state = stall_i ? WAIT : IDLE;
               end else if (timeout_hit) begin
                  busy_o     = 1'b0;
                  next_state = IDLE;
               end
            end
            WAIT: begin
               rd_data_o = rd_buf;
               if (!stall_i) next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_rw     <= BUS_WRITE;
         req_wdata  <= '0;
         rd_buf     <= '0;
         flush_seen <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            req_addr   <= addr_i;
            req_rw     <= rw_i;
            req_wdata  <= wr_data_i;
            flush_seen <= 1'b0;
         end
         if (state == ACCESS) begin
            if (flush_i) flush_seen <= 1'b1;
            if (bus_rdy_i && req_rw == BUS_READ && !flushed) rd_buf <= bus_rd_data_i;
         end
      end
   end

endmodule

// File: tb/tb_bus_if.sv
// Self-checking bench for bus_if: directed scenarios plus randomized transactions
// checked against a transaction-level expectation model.
module tb_bus_if;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i, busy_o;
   logic [29:0] addr_i;
   logic        as_i, rw_i;
   logic [31:0] wr_data_i, rd_data_o;
   logic        bus_req_o, bus_grant_i;
   logic [29:0] bus_addr_o;
   logic        bus_as_o, bus_rw_o;
   logic [31:0] bus_wr_data_o, bus_rd_data_i;
   logic        bus_rdy_i, bus_err_o;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] last_rd = 32'h0;   // data the last unflushed read delivered

   bus_if #(.WORD_DATA_WIDTH(32), .WORD_ADDR_WIDTH(30)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .busy_o(busy_o),
      .addr_i(addr_i), .as_i(as_i), .rw_i(rw_i), .wr_data_i(wr_data_i),
      .rd_data_o(rd_data_o), .bus_req_o(bus_req_o), .bus_grant_i(bus_grant_i),
      .bus_addr_o(bus_addr_o), .bus_as_o(bus_as_o), .bus_rw_o(bus_rw_o),
      .bus_wr_data_o(bus_wr_data_o), .bus_rd_data_i(bus_rd_data_i),
      .bus_rdy_i(bus_rdy_i), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      as_i = 1'b0; rw_i = 1'b0; addr_i = '0; wr_data_i = '0;
      stall_i = 1'b0; flush_i = 1'b0; bus_grant_i = 1'b0; bus_rdy_i = 1'b0;
      bus_rd_data_i = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1; as_i = 1'b1; rw_i = 1'b1; addr_i = 30'h3ff; wr_data_i = 32'hffff_ffff;
      bus_grant_i = 1'b1; bus_rdy_i = 1'b1; bus_rd_data_i = 32'hffff_ffff; stall_i = 1'b1;
      step; step;
      @(negedge clk);
      tests++;
      if ({busy_o, bus_req_o, bus_as_o, bus_rw_o, bus_err_o, bus_addr_o, bus_wr_data_o, rd_data_o} !== '0)
         begin fails++; $display("FAIL reset_outputs: busy/req/as/rw/err=%b%b%b%b%b addr=%h wd=%h rd=%h, want all 0",
                                 busy_o, bus_req_o, bus_as_o, bus_rw_o, bus_err_o, bus_addr_o, bus_wr_data_o, rd_data_o); end
      step;
      rst = 1'b0; idle_inputs();
      @(negedge clk);
      tests++;
      if ({busy_o, bus_req_o, bus_as_o} !== 3'b000 || rd_data_o !== 32'h0)
         begin fails++; $display("FAIL reset_idle: busy/req/as=%b%b%b rd=%h, want 000 / 0", busy_o, bus_req_o, bus_as_o, rd_data_o); end
      last_rd = 32'h0;
      step;
   endtask

   task automatic test_read;
      as_i = 1'b1; rw_i = 1'b1; addr_i = 30'h10;
      @(negedge clk);
      tests++;
      if ({busy_o, bus_req_o, bus_as_o} !== 3'b110)
         begin fails++; $display("FAIL read_n: busy/req/as=%b%b%b, want 110", busy_o, bus_req_o, bus_as_o); end
      step;
      as_i = 1'b0; addr_i = '0; bus_grant_i = 1'b1;
      @(negedge clk);
      tests++;
      if ({busy_o, bus_req_o, bus_as_o} !== 3'b110)
         begin fails++; $display("FAIL read_n1: busy/req/as=%b%b%b, want 110", busy_o, bus_req_o, bus_as_o); end
      step;
      bus_grant_i = 1'b0; bus_rdy_i = 1'b1; bus_rd_data_i = 32'hDEADBEEF;
      @(negedge clk);
      tests++;
      if ({busy_o, bus_as_o, bus_rw_o} !== 3'b011 || bus_addr_o !== 30'h10 || rd_data_o !== 32'hDEADBEEF)
         begin fails++; $display("FAIL read_n2: busy/as/rw=%b%b%b addr=%h rd=%h, want 011 10 deadbeef",
                                 busy_o, bus_as_o, bus_rw_o, bus_addr_o, rd_data_o); end
      last_rd = 32'hDEADBEEF;
      step;
      bus_rdy_i = 1'b0; bus_rd_data_i = '0;
      @(negedge clk);
      tests++;
      if ({busy_o, bus_req_o, bus_as_o} !== 3'b000 || rd_data_o !== 32'h0 || bus_addr_o !== 30'h0)
         begin fails++; $display("FAIL read_after: busy/req/as=%b%b%b rd=%h addr=%h, want 000 0 0",
                                 busy_o, bus_req_o, bus_as_o, rd_data_o, bus_addr_o); end
      step;
   endtask

   task automatic test_write;
      as_i = 1'b1; rw_i = 1'b0; addr_i = 30'h2a; wr_data_i = 32'h12345678;
      @(negedge clk);
      tests++;
      if (bus_as_o !== 1'b0 || bus_wr_data_o !== 32'h0)
         begin fails++; $display("FAIL write_req_as: as=%b wd=%h, want 0 0", bus_as_o, bus_wr_data_o); end
      step;
      as_i = 1'b0; wr_data_i = '0;
      for (int i = 0; i < 4; i++) begin
         bus_grant_i = (i == 3);
         @(negedge clk);
         tests++;
         if ({busy_o, bus_req_o, bus_as_o} !== 3'b110)
            begin fails++; $display("FAIL write_grant_wait%0d: busy/req/as=%b%b%b, want 110", i, busy_o, bus_req_o, bus_as_o); end
         step;
      end
      bus_grant_i = 1'b0; bus_rdy_i = 1'b1; bus_rd_data_i = 32'h5555AAAA;
      @(negedge clk);
      tests++;
      if ({bus_as_o, bus_rw_o, busy_o} !== 3'b100 || bus_wr_data_o !== 32'h12345678 || rd_data_o !== 32'h0)
         begin fails++; $display("FAIL write_access: as/rw/busy=%b%b%b wd=%h rd=%h, want 100 12345678 0",
                                 bus_as_o, bus_rw_o, busy_o, bus_wr_data_o, rd_data_o); end
      step;
      idle_inputs();
      @(negedge clk);
      tests++;
      if (bus_as_o !== 1'b0 || bus_wr_data_o !== 32'h0)
         begin fails++; $display("FAIL write_after: as=%b wd=%h, want 0 0", bus_as_o, bus_wr_data_o); end
      step;
   endtask

   task automatic test_stall_wait;
      as_i = 1'b1; rw_i = 1'b1; addr_i = 30'h44;
      step;
      as_i = 1'b0; bus_grant_i = 1'b1;
      step;
      bus_grant_i = 1'b0; bus_rdy_i = 1'b1; bus_rd_data_i = 32'hCAFEF00D; stall_i = 1'b1;
      @(negedge clk);
      tests++;
      if (rd_data_o !== 32'hCAFEF00D || busy_o !== 1'b0)
         begin fails++; $display("FAIL stall_complete: rd=%h busy=%b, want cafef00d 0", rd_data_o, busy_o); end
      last_rd = 32'hCAFEF00D;
      step;
      bus_rdy_i = 1'b0; bus_rd_data_i = 32'h0BAD0BAD;
      for (int i = 0; i < 2; i++) begin
         stall_i = (i == 0);
         @(negedge clk);
         tests++;
         if (rd_data_o !== 32'hCAFEF00D || {busy_o, bus_req_o, bus_as_o} !== 3'b000)
            begin fails++; $display("FAIL stall_wait%0d: rd=%h busy/req/as=%b%b%b, want cafef00d 000",
                                    i, rd_data_o, busy_o, bus_req_o, bus_as_o); end
         step;
      end
      @(negedge clk);
      tests++;
      if (rd_data_o !== 32'h0)
         begin fails++; $display("FAIL stall_idle: rd=%h, want 0", rd_data_o); end
      idle_inputs();
      step;
   endtask

   task automatic test_flush_req;
      as_i = 1'b1; rw_i = 1'b1; addr_i = 30'h77;
      step;
      as_i = 1'b0; bus_grant_i = 1'b1; flush_i = 1'b1;
      @(negedge clk);
      tests++;
      if (bus_req_o !== 1'b0 || bus_as_o !== 1'b0)
         begin fails++; $display("FAIL flush_req_cycle: req=%b as=%b, want 0 0", bus_req_o, bus_as_o); end
      step;
      bus_grant_i = 1'b0; flush_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus_grant_i = 1'b1;
         @(negedge clk);
         tests++;
         if ({busy_o, bus_req_o, bus_as_o} !== 3'b000)
            begin fails++; $display("FAIL flush_req_idle%0d: busy/req/as=%b%b%b, want 000", i, busy_o, bus_req_o, bus_as_o); end
         step;
      end
      idle_inputs();
   endtask

   task automatic test_flush_access;
      as_i = 1'b1; rw_i = 1'b1; addr_i = 30'h99;
      step;
      as_i = 1'b0; bus_grant_i = 1'b1;
      step;
      bus_grant_i = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      tests++;
      if (bus_as_o !== 1'b1 || busy_o !== 1'b1)
         begin fails++; $display("FAIL flush_acc_hold: as=%b busy=%b, want 1 1", bus_as_o, busy_o); end
      step;
      flush_i = 1'b0; bus_rdy_i = 1'b1; bus_rd_data_i = 32'h11112222; stall_i = 1'b1;
      @(negedge clk);
      tests++;
      if (rd_data_o !== 32'h0 || busy_o !== 1'b0 || bus_as_o !== 1'b1)
         begin fails++; $display("FAIL flush_acc_done: rd=%h busy=%b as=%b, want 0 0 1", rd_data_o, busy_o, bus_as_o); end
      step;
      bus_rdy_i = 1'b0; stall_i = 1'b0;
      @(negedge clk);
      tests++;
      if (rd_data_o !== last_rd)
         begin fails++; $display("FAIL flush_acc_rdbuf: rd=%h, want %h", rd_data_o, last_rd); end
      step;
      idle_inputs();
   endtask

   task automatic test_reset_mid_access;
      as_i = 1'b1; rw_i = 1'b1; addr_i = 30'h5;
      step;
      as_i = 1'b0; bus_grant_i = 1'b1;
      step;
      bus_grant_i = 1'b0;
      step;
      rst = 1'b1; bus_rdy_i = 1'b1; bus_rd_data_i = 32'h87654321;
      @(negedge clk);
      tests++;
      if ({busy_o, bus_req_o, bus_as_o} !== 3'b000 || rd_data_o !== 32'h0)
         begin fails++; $display("FAIL rst_mid_during: busy/req/as=%b%b%b rd=%h, want 000 0", busy_o, bus_req_o, bus_as_o, rd_data_o); end
      step;
      rst = 1'b0; last_rd = 32'h0;
      @(negedge clk);
      tests++;
      if ({busy_o, bus_req_o, bus_as_o} !== 3'b000 || rd_data_o !== 32'h0)
         begin fails++; $display("FAIL rst_mid_after: busy/req/as=%b%b%b rd=%h, want 000 0", busy_o, bus_req_o, bus_as_o, rd_data_o); end
      step;
      idle_inputs();
   endtask

`ifdef BUS_IF_TIMEOUT_EN
   task automatic test_timeout;
      int err_at;
      err_at = -1;
      as_i = 1'b1; rw_i = 1'b1; addr_i = 30'h123;
      step;
      as_i = 1'b0; bus_grant_i = 1'b1;
      step;
      bus_grant_i = 1'b0; bus_rd_data_i = 32'hFFFF0000;
      for (int i = 0; i < 300 && err_at < 0; i++) begin
         @(negedge clk);
         if (bus_err_o === 1'b1) begin
            err_at = i;
            tests++;
            if (busy_o !== 1'b0 || rd_data_o !== 32'h0)
               begin fails++; $display("FAIL timeout_outputs: busy=%b rd=%h, want 0 0", busy_o, rd_data_o); end
         end
         step;
      end
      tests++;
      if (err_at !== 254)
         begin fails++; $display("FAIL timeout_cycle: err at ACCESS cycle %0d, want 254", err_at); end
      @(negedge clk);
      tests++;
      if ({bus_err_o, bus_as_o, bus_req_o, busy_o} !== 4'b0000)
         begin fails++; $display("FAIL timeout_idle: err/as/req/busy=%b%b%b%b, want 0000", bus_err_o, bus_as_o, bus_req_o, busy_o); end
      step;
      idle_inputs();
   endtask
`endif

   task automatic test_random;
      for (int t = 0; t < 40; t++) begin
         logic        rw, flushed;
         logic [29:0] a;
         logic [31:0] wd, rdv, expd;
         int          g, r, s, fl_at;
         bit          abort;
         rw = 1'($urandom_range(0, 1)); a = 30'($urandom); wd = $urandom; rdv = $urandom;
         g = $urandom_range(0, 3); r = $urandom_range(0, 3); s = $urandom_range(0, 2);
         fl_at = $urandom_range(0, 6); abort = ($urandom_range(0, 7) == 0);
         flushed = 1'b0;
         as_i = 1'b1; rw_i = rw; addr_i = a; wr_data_i = wd;
         @(negedge clk);
         tests++;
         if ({busy_o, bus_req_o, bus_as_o} !== 3'b110 || rd_data_o !== 32'h0)
            begin fails++; $display("FAIL rnd%0d_accept: busy/req/as=%b%b%b rd=%h", t, busy_o, bus_req_o, bus_as_o, rd_data_o); end
         step;
         // Requests arriving while busy are noise that must be ignored.
         for (int i = 0; i <= g; i++) begin
            as_i = 1'($urandom_range(0, 1)); addr_i = 30'($urandom); rw_i = ~rw; wr_data_i = $urandom;
            bus_grant_i = (i == g); flush_i = abort && (i == g);
            @(negedge clk);
            tests++;
            if (flush_i ? ({bus_req_o, bus_as_o} !== 2'b00) : ({busy_o, bus_req_o, bus_as_o} !== 3'b110 || rd_data_o !== 32'h0))
               begin fails++; $display("FAIL rnd%0d_req%0d: busy/req/as=%b%b%b rd=%h flush=%b", t, i, busy_o, bus_req_o, bus_as_o, rd_data_o, flush_i); end
            step;
         end
         bus_grant_i = 1'b0;
         if (abort) begin
            flush_i = 1'b0; as_i = 1'b0;
            @(negedge clk);
            tests++;
            if ({busy_o, bus_req_o, bus_as_o} !== 3'b000)
               begin fails++; $display("FAIL rnd%0d_abort: busy/req/as=%b%b%b, want 000", t, busy_o, bus_req_o, bus_as_o); end
            step;
            continue;
         end
         for (int i = 0; i <= r; i++) begin
            bus_rdy_i = (i == r); flush_i = (i == fl_at); stall_i = (i == r) && (s > 0);
            bus_rd_data_i = (i == r) ? rdv : $urandom;
            if (flush_i) flushed = 1'b1;
            @(negedge clk);
            tests++;
            if ({bus_as_o, bus_req_o, bus_rw_o} !== {2'b11, rw} || bus_addr_o !== a || bus_wr_data_o !== wd)
               begin fails++; $display("FAIL rnd%0d_acc%0d: as/req/rw=%b%b%b addr=%h wd=%h, want 11%b %h %h",
                                       t, i, bus_as_o, bus_req_o, bus_rw_o, bus_addr_o, bus_wr_data_o, rw, a, wd); end
            if (i == r) begin
               expd = (rw && !flushed) ? rdv : 32'h0;
               tests++;
               if (rd_data_o !== expd || busy_o !== 1'b0)
                  begin fails++; $display("FAIL rnd%0d_done: rd=%h busy=%b, want %h 0", t, rd_data_o, busy_o, expd); end
               if (rw && !flushed) last_rd = rdv;
            end else begin
               tests++;
               if (busy_o !== 1'b1)
                  begin fails++; $display("FAIL rnd%0d_busy%0d: busy=%b, want 1", t, i, busy_o); end
            end
            step;
         end
         bus_rdy_i = 1'b0; flush_i = 1'b0; as_i = 1'b0;
         for (int i = 0; i < s; i++) begin
            stall_i = (i < s - 1);
            @(negedge clk);
            tests++;
            if (rd_data_o !== last_rd || {busy_o, bus_req_o, bus_as_o} !== 3'b000)
               begin fails++; $display("FAIL rnd%0d_wait%0d: rd=%h busy/req/as=%b%b%b, want %h 000",
                                       t, i, rd_data_o, busy_o, bus_req_o, bus_as_o, last_rd); end
            step;
         end
         idle_inputs();
         @(negedge clk);
         tests++;
         if ({busy_o, bus_req_o, bus_as_o} !== 3'b000 || rd_data_o !== 32'h0)
            begin fails++; $display("FAIL rnd%0d_idle: busy/req/as=%b%b%b rd=%h, want 000 0", t, busy_o, bus_req_o, bus_as_o, rd_data_o); end
         step;
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_read();
      test_write();
      test_stall_wait();
      test_flush_req();
      test_flush_access();
      test_reset_mid_access();
`ifdef BUS_IF_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, limit 2000000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
